// File: rtl/kf_sa_pkg.sv
// Shared types and constants for the Kalman-filter systolic-array arbiter.
// The IEEE-754 constants and enable bit positions are shared with the array's clients.
package kf_sa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sa_arb_state_t;

    localparam logic [63:0] FP_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] FP_ONE  = 64'h3FF0_0000_0000_0000;

    // Bit positions inside the 3-bit enable bundle {enb_7_12, enb_2_6, enb_1}.
    localparam int ENB_1    = 0;
    localparam int ENB_2_6  = 1;
    localparam int ENB_7_12 = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_share_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from ptr, wrapping at NREQ.
// Purely combinational; the caller registers the result.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int slot;

    always_comb begin
        grant = '0;
        idx   = '0;
        slot  = 0;
        for (int k = 0; k < NREQ; k++) begin
            slot = (int'(ptr) + k) % NREQ;
            if ((grant == '0) && req[slot]) begin
                grant[slot] = 1'b1;
                idx         = IW'(slot);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sa_share_arbiter.sv
// Time-shares one systolic-array matmul engine between NREQ requesters with
// round-robin grants, a registered owner, result capture and a run watchdog.
module sa_share_arbiter
    import kf_sa_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int N       = 12,
    parameter int DWIDTH  = 64,
    parameter int TIMEOUT = 64
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NREQ-1:0]                           req,
    input  logic [NREQ-1:0][N-1:0][N-1:0][DWIDTH-1:0] req_a,
    input  logic [NREQ-1:0][N-1:0][N-1:0][DWIDTH-1:0] req_b,
    input  logic [NREQ-1:0][2:0]                      req_enb,
    output logic [NREQ-1:0]                           gnt,
    output logic [NREQ-1:0]                           done,
    output logic                                      err,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]           c_hold,
    output logic                                      busy,
    output logic                                      sa_load_en,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]           sa_a,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]           sa_b,
    output logic [2:0]                                sa_enb,
    input  logic [N-1:0][N-1:0][DWIDTH-1:0]           sa_c,
    input  logic                                      sa_done
);

    localparam int IW = idx_width(NREQ);
    localparam int WW = idx_width(TIMEOUT);

    sa_arb_state_t   state;
    sa_arb_state_t   state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] owner_oh;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            pick_any;
    logic [WW-1:0]   wd;
    logic            wd_expired;
    logic            err_flag;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign wd_expired = (wd == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sa_done has priority over the watchdog when both land on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (sa_done || wd_expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        sa_load_en = (state == LOAD);
        gnt        = busy ? owner_oh : '0;
        done       = (state == DONE) ? owner_oh : '0;
        err        = (state == DONE) && err_flag;
        sa_a       = '0;
        sa_b       = '0;
        sa_enb     = 3'b000;
        if (busy) begin
            sa_a   = req_a[owner];
            sa_b   = req_b[owner];
            sa_enb = req_enb[owner];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            owner_oh <= '0;
            wd       <= '0;
            err_flag <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    c_hold[i][j] <= DWIDTH'(FP_ZERO);
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    wd       <= '0;
                    err_flag <= 1'b0;
                    if (pick_any) begin
                        owner    <= pick_idx;
                        owner_oh <= pick_oh;
                    end
                end
                LOAD: begin
                    wd <= '0;
                end
                RUN: begin
                    if (sa_done) begin
                        c_hold <= sa_c;
                    end else if (wd_expired) begin
                        err_flag <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    wd  <= '0;
                    ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: begin
                    wd <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_share_arbiter.sv
// Bench for sa_share_arbiter: directed request scenarios, a behavioural array that
// returns C = A*I, and a scoreboard that checks every grant and done pulse.
module tb_sa_share_arbiter;
    import kf_sa_pkg::*;

    localparam int NREQ    = 3;
    localparam int N       = 12;
    localparam int DW      = 64;
    localparam int TIMEOUT = 64;

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

    logic                      clk;
    logic                      rst;
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0][N-1:0][N-1:0][DW-1:0] req_a;
    logic [NREQ-1:0][N-1:0][N-1:0][DW-1:0] req_b;
    logic [NREQ-1:0][2:0]      req_enb;
    logic [NREQ-1:0]           gnt;
    logic [NREQ-1:0]           done;
    logic                      err;
    mat_t                      c_hold;
    logic                      busy;
    logic                      sa_load_en;
    mat_t                      sa_a;
    mat_t                      sa_b;
    logic [2:0]                sa_enb;
    mat_t                      sa_c;
    logic                      sa_done;

    sa_share_arbiter #(
        .NREQ    (NREQ),
        .N       (N),
        .DWIDTH  (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_enb    (req_enb),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .c_hold     (c_hold),
        .busy       (busy),
        .sa_load_en (sa_load_en),
        .sa_a       (sa_a),
        .sa_b       (sa_b),
        .sa_enb     (sa_enb),
        .sa_c       (sa_c),
        .sa_done    (sa_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int load_total = 0;
    int load_cnt = 0;
    int last_load_cyc = 0;
    int last_finish_cyc = 0;

    // entry: [4:3] owner, [2] err, [1:0] c_hold source (3 = all zero)
    logic [4:0] exp_q[$];

    function automatic mat_t a_pat(input int r);
        mat_t m = '0;
        if (r < NREQ) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    m[i][j] = {8'(8'hA0 + r), 40'h0, 8'(i), 8'(j)};
        end
        return m;
    endfunction

    function automatic mat_t ident();
        mat_t m = '0;
        for (int i = 0; i < N; i++) m[i][i] = FP_ONE;
        return m;
    endfunction

    function automatic logic [2:0] enb_of(input int r);
        logic [2:0] e = 3'b000;
        e[ENB_1] = 1'b1;
        if (r >= 1) e[ENB_2_6] = 1'b1;
        if (r >= 2) e[ENB_7_12] = 1'b1;
        return e;
    endfunction

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic void chk_mat(input string name, input mat_t got, input mat_t want);
        bit shown = 0;
        checks++;
        if (got !== want) begin
            failures++;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (!shown && got[i][j] !== want[i][j]) begin
                        shown = 1;
                        $display("FAIL %s: [%0d][%0d] got %h want %h (cycle %0d)",
                                 name, i, j, got[i][j], want[i][j], cyc);
                    end
        end
    endfunction

    // ---------------- behavioural array ----------------
    int   model_lat  = 14;
    bit   model_hang = 0;
    bit   spur_req   = 0;
    bit   pending    = 0;
    int   cnt        = 0;
    mat_t captured;

    initial begin
        sa_done  = 1'b0;
        sa_c     = '0;
        captured = '0;
        forever begin
            @(negedge clk);
            sa_done = 1'b0;
            if (rst) begin
                pending = 0;
            end else if (spur_req) begin
                sa_done  = 1'b1;
                sa_c     = '1;
                spur_req = 0;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending         = 0;
                    sa_done         = 1'b1;
                    sa_c            = captured;
                    last_finish_cyc = cyc;
                end
            end else if (sa_load_en && !model_hang) begin
                pending  = 1;
                cnt      = model_lat;
                captured = sa_a;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [4:0] e;
        int o;
        int want_cyc;
        forever begin
            @(negedge clk);
            if (rst) begin
                load_cnt = 0;
            end else begin
                if (sa_load_en) begin
                    load_cnt++;
                    load_total++;
                    last_load_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_load: gnt %b with empty queue (cycle %0d)", gnt, cyc);
                    end else begin
                        e = exp_q[0];
                        o = int'(e[4:3]);
                        chk("load_gnt", 64'(gnt), 64'(3'b001 << o));
                        chk_mat("load_sa_a", sa_a, a_pat(o));
                        chk_mat("load_sa_b", sa_b, ident());
                        chk("load_sa_enb", 64'(sa_enb), 64'(enb_of(o)));
                    end
                end
                if (done != '0) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: done %b with empty queue (cycle %0d)", done, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        o = int'(e[4:3]);
                        want_cyc = e[2] ? (last_load_cyc + TIMEOUT + 1) : (last_finish_cyc + 1);
                        chk("done_owner", 64'(done), 64'(3'b001 << o));
                        chk("done_gnt", 64'(gnt), 64'(3'b001 << o));
                        chk("done_err", 64'(err), 64'(e[2]));
                        chk_mat("done_c_hold", c_hold, a_pat(int'(e[1:0])));
                        chk("done_one_load", 64'(load_cnt), 64'd1);
                        chk("done_timing", 64'(cyc), 64'(want_cyc));
                    end
                    load_cnt = 0;
                end else if (err) begin
                    checks++;
                    failures++;
                    $display("FAIL err_without_done: err %b (cycle %0d)", err, cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            step(1);
            n++;
        end
        chk(name, 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_load(input int target, input string name);
        int n = 0;
        while (load_total < target && n < 300) begin
            step(1);
            n++;
        end
        chk(name, 64'(load_total), 64'(target));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_load_en"}, 64'(sa_load_en), 64'd0);
        chk({tag, "_sa_enb"}, 64'(sa_enb), 64'd0);
        chk_mat({tag, "_sa_a"}, sa_a, '0);
        chk_mat({tag, "_c_hold"}, c_hold, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int t_req;
        rst = 1'b1;
        req = '0;
        for (int r = 0; r < NREQ; r++) begin
            req_a[r]   = a_pat(r);
            req_b[r]   = ident();
            req_enb[r] = enb_of(r);
        end
        step(3);
        chk_idle_outputs("reset");
        rst = 1'b0;
        step(2);
        chk_idle_outputs("post_reset");

        // single requester 1, array finishes 14 cycles after load
        base = done_cnt;
        exp_q.push_back({2'd1, 1'b0, 2'd1});
        model_lat = 14;
        t_req = cyc;
        req = 3'b010;
        wait_load(1, "t1_load_seen");
        chk("t1_load_latency", 64'(last_load_cyc), 64'(t_req + 1));
        wait_done(base + 1, "t1_done");
        req = '0;
        step(3);

        // requester 0 drops its request mid-run; done must still arrive
        base = done_cnt;
        exp_q.push_back({2'd0, 1'b0, 2'd0});
        model_lat = 10;
        req = 3'b001;
        wait_load(2, "drop_load_seen");
        step(2);
        req = '0;
        chk("drop_busy", 64'(busy), 64'd1);
        wait_done(base + 1, "drop_done");
        step(3);

        // requesters 0 and 2 with ptr = 1: owner 2 first, then 0
        base = done_cnt;
        exp_q.push_back({2'd2, 1'b0, 2'd2});
        exp_q.push_back({2'd0, 1'b0, 2'd0});
        model_lat = 4;
        req = 3'b101;
        wait_done(base + 2, "pair_done");
        req = '0;
        step(3);

        // watchdog: array never finishes, c_hold keeps requester 0's result
        base = done_cnt;
        exp_q.push_back({2'd2, 1'b1, 2'd0});
        model_hang = 1;
        req = 3'b100;
        wait_done(base + 1, "timeout_done");
        req = '0;
        model_hang = 0;
        step(2);
        chk("timeout_idle_busy", 64'(busy), 64'd0);
        step(1);

        // all three held continuously from ptr = 0
        base = done_cnt;
        exp_q.push_back({2'd0, 1'b0, 2'd0});
        exp_q.push_back({2'd1, 1'b0, 2'd1});
        exp_q.push_back({2'd2, 1'b0, 2'd2});
        exp_q.push_back({2'd0, 1'b0, 2'd0});
        model_lat = 3;
        req = 3'b111;
        wait_done(base + 4, "rr_done");
        req = '0;
        step(3);

        // sa_done on the watchdog-expiry cycle wins over the timeout
        base = done_cnt;
        exp_q.push_back({2'd1, 1'b0, 2'd1});
        model_lat = TIMEOUT;
        req = 3'b010;
        wait_done(base + 1, "expiry_done");
        req = '0;
        step(3);

        // spurious sa_done while idle: no capture, no done
        base = done_cnt;
        spur_req = 1;
        step(4);
        chk_mat("spur_c_hold", c_hold, a_pat(1));
        chk("spur_no_done", 64'(done_cnt), 64'(base));
        chk("spur_busy", 64'(busy), 64'd0);

        // reset in the middle of a run, then a fresh grant to requester 2
        base = done_cnt;
        exp_q.push_back({2'd0, 1'b0, 2'd0});
        model_lat = 20;
        req = 3'b001;
        wait_load(load_total + 1, "rst_load_seen");
        req = '0;
        step(4);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        step(2);
        void'(exp_q.pop_front());
        rst = 1'b0;
        step(3);
        chk("rst_no_done", 64'(done_cnt), 64'(base));
        exp_q.push_back({2'd2, 1'b0, 2'd2});
        model_lat = 5;
        req = 3'b100;
        wait_done(base + 1, "after_rst_done");
        req = '0;
        step(5);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
